// File: rtl/karat_mult_issue_if.sv
// Handshake bundle between karat_mult_issue, its upstream producer, the
// multi-cycle multiplier, and the downstream product consumer.
interface karat_mult_issue_if #(
    parameter int wI    = 512,
    parameter int TAG_W = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [wI-1:0]     iX;
    logic [wI-1:0]     iY;
    logic              o_mul_en;
    logic [wI-1:0]     oX;
    logic [wI-1:0]     oY;
    logic              i_mul_finish;
    logic [2*wI-1:0]   i_mul_prod;
    logic              o_valid;
    logic              i_ready;
    logic [2*wI-1:0]   oO;
    logic [TAG_W-1:0]  o_tag;
    logic              o_busy;
    logic              o_err;

    modport slave (
        input  i_valid, iX, iY, i_mul_finish, i_mul_prod, i_ready,
        output o_ready, o_mul_en, oX, oY, o_valid, oO, o_tag, o_busy, o_err
    );

    modport master (
        output i_valid, iX, iY, i_mul_finish, i_mul_prod, i_ready,
        input  o_ready, o_mul_en, oX, oY, o_valid, oO, o_tag, o_busy, o_err
    );
endinterface

// File: rtl/karat_mult_issue.sv
// Operand FIFO, one-job-at-a-time issue FSM and product capture register for
// karat_mult_recursion. Define KARAT_ISSUE_TAG_EN to attach sequence tags.
module karat_mult_issue #(
    parameter int wI    = 512,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    karat_mult_issue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                o_ready_q, o_ready_d;
    logic [wI-1:0]       ox_q, ox_d;
    logic [wI-1:0]       oy_q, oy_d;
    logic [2*wI-1:0]     oo_q, oo_d;
    logic                o_valid_q, o_valid_d;
    logic                o_err_q, o_err_d;
    logic [wI-1:0]       mem_x_q [DEPTH];
    logic [wI-1:0]       mem_y_q [DEPTH];
    logic                push, pop;

`ifdef KARAT_ISSUE_TAG_EN
    logic [TAG_W-1:0]    tag_cnt_q, tag_cnt_d;
    logic [TAG_W-1:0]    job_tag_q, job_tag_d;
    logic [TAG_W-1:0]    o_tag_q, o_tag_d;
    logic [TAG_W-1:0]    mem_tag_q [DEPTH];
`endif

    always_comb begin
        push      = bus.i_valid && o_ready_q;
        pop       = (state_q == IDLE) && (count_q != '0) && (!o_valid_q || bus.i_ready);
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        oo_d      = oo_q;
        o_valid_d = o_valid_q;
        o_err_d   = o_err_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        o_ready_d = (count_d < DEPTH_C);
`ifdef KARAT_ISSUE_TAG_EN
        tag_cnt_d = push ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;
        job_tag_d = job_tag_q;
        o_tag_d   = o_tag_q;
`endif

        // A capture on the same edge as a downstream accept wins over the clear.
        if (o_valid_q && bus.i_ready) begin
            o_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_mul_finish) begin
                    o_err_d = 1'b1;
                end
                if (pop) begin
                    state_d = BUSY;
                    ox_d    = mem_x_q[rd_ptr_q];
                    oy_d    = mem_y_q[rd_ptr_q];
`ifdef KARAT_ISSUE_TAG_EN
                    job_tag_d = mem_tag_q[rd_ptr_q];
`endif
                end
            end
            BUSY: begin
                if (bus.i_mul_finish) begin
                    state_d   = IDLE;
                    oo_d      = bus.i_mul_prod;
                    o_valid_d = 1'b1;
`ifdef KARAT_ISSUE_TAG_EN
                    o_tag_d   = job_tag_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            o_ready_q <= 1'b1;
            ox_q      <= '0;
            oy_q      <= '0;
            oo_q      <= '0;
            o_valid_q <= 1'b0;
            o_err_q   <= 1'b0;
`ifdef KARAT_ISSUE_TAG_EN
            tag_cnt_q <= '0;
            job_tag_q <= '0;
            o_tag_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            o_ready_q <= o_ready_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            oo_q      <= oo_d;
            o_valid_q <= o_valid_d;
            o_err_q   <= o_err_d;
`ifdef KARAT_ISSUE_TAG_EN
            tag_cnt_q <= tag_cnt_d;
            job_tag_q <= job_tag_d;
            o_tag_q   <= o_tag_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x_q[wr_ptr_q] <= bus.iX;
            mem_y_q[wr_ptr_q] <= bus.iY;
`ifdef KARAT_ISSUE_TAG_EN
            mem_tag_q[wr_ptr_q] <= tag_cnt_q;
`endif
        end
    end

    assign bus.o_ready  = o_ready_q;
    assign bus.o_mul_en = (state_q == BUSY);
    assign bus.o_busy   = (state_q == BUSY);
    assign bus.oX       = ox_q;
    assign bus.oY       = oy_q;
    assign bus.oO       = oo_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_err    = o_err_q;
`ifdef KARAT_ISSUE_TAG_EN
    assign bus.o_tag    = o_tag_q;
`else
    assign bus.o_tag    = {TAG_W{1'b0}};
`endif
endmodule

// File: doc/karat_mult_issue.md
# karat_mult_issue

Operand issue and result capture stage placed directly upstream of `karat_mult_recursion`.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Drives the multiplier's enable and operand inputs one job at a time, holding operands stable until the multiplier's finish pulse.
- Latches the `2*wI`-bit product into a backpressured output register, so the multi-cycle multiplier can sit in a streaming MSM datapath.

## Interface
Parameters:
- `wI`, 512, operand width; product width is `2*wI`.
- `DEPTH`, 4, operand FIFO entries; power of two, ≥2.
- `TAG_W`, 8, sequence tag width (used only with `KARAT_ISSUE_TAG_EN`).

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `i_valid` input 1: upstream operand pair valid.
- `o_ready` output 1: FIFO can accept; registered, equals `count < DEPTH`.
- `iX`, `iY` input `wI`: operands.
- `o_mul_en` output 1: to multiplier `i_enable`.
- `oX`, `oY` output `wI`: to multiplier `iX`/`iY`.
- `i_mul_finish` input 1: multiplier `o_finish`.
- `i_mul_prod` input `2*wI`: multiplier `oO`.
- `o_valid` output 1: product register full.
- `i_ready` input 1: downstream accepts product.
- `oO` output `2*wI`: captured product.
- `o_tag` output `TAG_W`: tag of `oO`; tied 0 when the macro is off.
- `o_busy` output 1: job in flight.
- `o_err` output 1: sticky protocol error.

## Operation
- **FIFO**
  - Push at an edge where `i_valid && o_ready`.
  - No push while full, even if a pop occurs the same edge.
  - Push and pop on the same edge is allowed when not full; count is unchanged.
  - Pointers wrap modulo `DEPTH`.
- **FSM IDLE**
  - Go to BUSY when the FIFO is not empty and `(!o_valid || i_ready)`.
  - On that edge: pop the head, load `oX`/`oY`, set `o_mul_en=1` and `o_busy=1`.
- **FSM BUSY**
  - `oX`/`oY` are frozen.
  - On an edge with `i_mul_finish=1`:
    - load `oO <= i_mul_prod` and set `o_valid=1`;
    - clear `o_mul_en` and `o_busy`;
    - go to IDLE.
  - After finish, `o_mul_en` is low for at least one cycle before the next issue.
- **Output register**
  - `o_valid` clears at an edge where `o_valid && i_ready`, unless a capture happens on the same edge.
  - Capture while `o_valid && !i_ready` cannot occur, because the issue condition prevents it.
- **Error**
  - `i_mul_finish` sampled in IDLE sets `o_err`.
  - The stray pulse is otherwise ignored: no capture, no state change.
- **Arithmetic**
  - No arithmetic in this block; operands and product pass bit-exact.
- **Reset**
  - Reset mid-operation aborts the in-flight job, empties the FIFO and returns to IDLE.
  - The multiplier shares `reset`.

## Timing
- **Reset values**
  - Flags: `o_ready=1`, `o_mul_en=0`, `o_valid=0`, `o_busy=0`, `o_err=0`.
  - Data: `oX=oY=0`, `oO=0`, `o_tag=0`.
  - Tag counter: 0.
- **Issue latency**
  - Pair pushed at edge k into an empty FIFO, with output free: `o_mul_en` rises after edge k+1.
- **Capture latency**
  - Finish sampled at edge f: `o_valid=1` and `oO` valid after edge f.
  - Earliest next `o_mul_en` is after edge f+1.
- **Back-to-back**
  - Next issue can occur at edge f+1 if FIFO is not empty and `(!o_valid || i_ready)` at f+1.
- **Combinational paths**
  - `o_ready` has no combinational path from `i_valid`.
  - `o_valid` has no combinational path from `i_ready`.

## Configuration
- **`KARAT_ISSUE_TAG_EN` defined**
  - Each accepted pair gets the current `TAG_W`-bit counter value, stored alongside it in the FIFO.
  - The counter increments on every push and wraps modulo `2^TAG_W`.
  - The tag travels with the job and is loaded into `o_tag` with `oO`.
- **Not defined**
  - No tag storage or counter.
  - `o_tag` is constant 0.

## Test plan
- **Reset defaults:** assert `reset` 2 cycles, then release → all outputs at reset values; `o_ready=1`.
- **Single job:** push `iX=3`, `iY=5`; model finish 6 cycles after `o_mul_en`, with `i_mul_prod=15`.
  - `o_mul_en` high from the edge after the push until finish.
  - `oX=3`, `oY=5` stable throughout.
  - `o_valid=1` with `oO=15`.
  - With `i_ready=1`, `o_valid` clears the next edge.
- **Fill and backpressure:** `DEPTH=4`, push 6 pairs with `i_ready=0`.
  - `o_ready` drops after the 5th accept: 4 stored plus 1 issued.
  - Only 1 result is captured; no second issue while `o_valid=1`.
  - Raising `i_ready` drains all 5 remaining results in push order.
- **Random 512-bit streaming:** 100 random pairs through the real `karat_mult_recursion`, with random `i_ready`.
  - Every `oO == X*Y` in order.
  - `o_err` stays 0.
  - With `KARAT_ISSUE_TAG_EN`, tags run 0..99 (mod 256).
- **Stray finish:** pulse `i_mul_finish` in IDLE → `o_err=1` and sticky; `o_valid` unchanged; cleared only by `reset`.
- **Reset mid-job:** assert `reset` while BUSY with 3 pairs queued → after the edge, `o_mul_en=0`, FIFO empty, `o_valid=0`, tag counter 0; no output appears afterwards.
